// File: rtl/vga_sync.sv
// VGA timing generator: clk/4 pixel strobe, pixel and line counters, and
// registered active-low syncs that change on the same edge as the counters.
module vga_sync #(
    parameter int H_DISP = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_DISP = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int HT = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int VT = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_MAX        = 10'(HT - 1);
    localparam logic [9:0] V_MAX        = 10'(VT - 1);
    localparam logic [9:0] H_VIS        = 10'(H_DISP);
    localparam logic [9:0] V_VIS        = 10'(V_DISP);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_DISP + H_FP);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_DISP + V_FP);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_DISP + V_FP + V_SYNC - 1);

    logic [1:0] div;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_next;
    logic [9:0] v_next;

    // Out-of-range counts fall back to 0 on the next tick instead of running on.
    always_comb begin
        h_next = h_cnt;
        v_next = v_cnt;
        if (p_tick) begin
            h_next = (h_cnt >= H_MAX) ? 10'd0 : h_cnt + 10'd1;
            if (v_cnt > V_MAX) begin
                v_next = 10'd0;
            end else if (h_cnt == H_MAX) begin
                v_next = (v_cnt == V_MAX) ? 10'd0 : v_cnt + 10'd1;
            end
        end
    end

    // Syncs are decoded from the next counter values so they line up with pixel_x/pixel_y.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div         <= 2'd0;
            p_tick      <= 1'b0;
            h_cnt       <= 10'd0;
            v_cnt       <= 10'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            div         <= div + 2'd1;
            p_tick      <= (div == 2'd2);
            frame_start <= (div == 2'd2) && (h_cnt == 10'd0) && (v_cnt == 10'd0);
            h_cnt       <= h_next;
            v_cnt       <= v_next;
            hsync       <= !((h_next >= H_SYNC_FIRST) && (h_next <= H_SYNC_LAST));
            vsync       <= !((v_next >= V_SYNC_FIRST) && (v_next <= V_SYNC_LAST));
        end
    end

    assign pixel_x  = h_cnt;
    assign pixel_y  = v_cnt;
    assign video_on = (h_cnt < H_VIS) && (v_cnt < V_VIS);

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a full-size instance for line-level timing and a
// shrunken-timing instance for frame, wrap and reset behaviour.
`timescale 1ns/1ps
module tb_vga_sync;

    localparam int SH_DISP = 16;
    localparam int SH_FP   = 4;
    localparam int SH_SYNC = 6;
    localparam int SH_BP   = 6;
    localparam int SV_DISP = 10;
    localparam int SV_FP   = 2;
    localparam int SV_SYNC = 2;
    localparam int SV_BP   = 3;
    localparam int SHT     = SH_DISP + SH_FP + SH_SYNC + SH_BP;
    localparam int SVT     = SV_DISP + SV_FP + SV_SYNC + SV_BP;

    typedef struct {
        int cyc;
        int x;
        int y;
        int hs;
        int vs;
        int von;
        int fs;
    } exp_t;

    logic       clk;
    logic       rst_n_d;
    logic       rst_n_s;
    logic       d_p_tick, d_video_on, d_hsync, d_vsync, d_frame_start;
    logic [9:0] d_pixel_x, d_pixel_y;
    logic       s_p_tick, s_video_on, s_hsync, s_vsync, s_frame_start;
    logic [9:0] s_pixel_x, s_pixel_y;
    logic [10:0] d_rom_addr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int s_cnt = 0;
    exp_t sb_q[$];

    vga_sync dut (
        .clk(clk), .reset(rst_n_d), .p_tick(d_p_tick),
        .pixel_x(d_pixel_x), .pixel_y(d_pixel_y), .video_on(d_video_on),
        .hsync(d_hsync), .vsync(d_vsync), .frame_start(d_frame_start)
    );

    vga_sync #(
        .H_DISP(SH_DISP), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
        .V_DISP(SV_DISP), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
    ) dut_s (
        .clk(clk), .reset(rst_n_s), .p_tick(s_p_tick),
        .pixel_x(s_pixel_x), .pixel_y(s_pixel_y), .video_on(s_video_on),
        .hsync(s_hsync), .vsync(s_vsync), .frame_start(s_frame_start)
    );

    // Character-row addressing as the text generator uses it: low nibble is the glyph row.
    assign d_rom_addr = {d_pixel_x[9:3], d_pixel_y[3:0]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected outputs n clk edges after reset release, from plain timing arithmetic.
    function automatic exp_t model_at(input int n);
        exp_t e;
        int p;
        p     = n / 4;
        e.cyc = 0;
        e.x   = p % SHT;
        e.y   = (p / SHT) % SVT;
        e.hs  = ((e.x >= SH_DISP + SH_FP) && (e.x < SH_DISP + SH_FP + SH_SYNC)) ? 0 : 1;
        e.vs  = ((e.y >= SV_DISP + SV_FP) && (e.y < SV_DISP + SV_FP + SV_SYNC)) ? 0 : 1;
        e.von = ((e.x < SH_DISP) && (e.y < SV_DISP)) ? 1 : 0;
        e.fs  = ((e.x == 0) && (e.y == 0)) ? 1 : 0;
        return e;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n_s) begin
                s_cnt = 0;
            end else begin
                s_cnt++;
                if (s_cnt % 4 == 3) begin
                    e     = model_at(s_cnt);
                    e.cyc = cyc;
                    sb_q.push_back(e);
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (s_p_tick) begin
                check_output("sb_queue_depth", sb_q.size(), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check_output("sb_tick_cycle", cyc, e.cyc);
                    check_output("sb_pixel_x", int'(s_pixel_x), e.x);
                    check_output("sb_pixel_y", int'(s_pixel_y), e.y);
                    check_output("sb_hsync", int'(s_hsync), e.hs);
                    check_output("sb_vsync", int'(s_vsync), e.vs);
                    check_output("sb_video_on", int'(s_video_on), e.von);
                    check_output("sb_frame_start", int'(s_frame_start), e.fs);
                end
            end
        end
    end

    task automatic run_default();
        int n;
        int last;
        @(negedge clk);
        #2 rst_n_d = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check_output("d_ptick_after_edge", int'(d_p_tick), (k == 3) ? 1 : 0);
        end
        check_output("d_first_tick_frame_start", int'(d_frame_start), 1);
        @(posedge clk);
        #1;
        check_output("d_ptick_after_edge4", int'(d_p_tick), 0);
        check_output("d_x_after_first_tick", int'(d_pixel_x), 1);
        last = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (d_p_tick) begin
                if (last >= 0) check_output("d_tick_period", k - last, 4);
                last = k;
            end
        end
        n = 0;
        @(negedge clk);
        while (d_hsync && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check_output("d_hsync_fall_seen", (n < 4000) ? 1 : 0, 1);
        check_output("d_hsync_fall_x", int'(d_pixel_x), 656);
        n = 0;
        while (!d_hsync && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check_output("d_hsync_low_clk", n, 384);
        check_output("d_hsync_rise_x", int'(d_pixel_x), 752);
        n = 0;
        while (!(d_p_tick && d_pixel_x == 10'd799) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_output("d_line_end_seen", (n < 2000) ? 1 : 0, 1);
        check_output("d_y_before_wrap", int'(d_pixel_y), 0);
        @(posedge clk);
        #1;
        check_output("d_x_wrap", int'(d_pixel_x), 0);
        check_output("d_y_increment", int'(d_pixel_y), 1);
        n = 0;
        while (!(d_pixel_x == 10'd8 && d_pixel_y == 10'd3) && n < 12000) begin
            @(negedge clk);
            n++;
        end
        check_output("d_pixel_8_3_seen", (n < 12000) ? 1 : 0, 1);
        for (int k = 0; k < 4; k++) begin
            check_output("d_rom_addr_row", int'(d_rom_addr[3:0]), 3);
            check_output("d_pixel_hold_x", int'(d_pixel_x), 8);
            @(negedge clk);
        end
        check_output("d_pixel_next_x", int'(d_pixel_x), 9);
    endtask

    task automatic measure_frame(output int period, output int vs_low,
                                 output int vid_ticks, output int bad_vs, output int wait_n);
        wait_n = 0;
        while (!s_frame_start && wait_n < 3000) begin
            @(negedge clk);
            wait_n++;
        end
        period    = 0;
        vs_low    = 0;
        vid_ticks = 0;
        bad_vs    = 0;
        do begin
            if (!s_vsync) begin
                vs_low++;
                if (s_pixel_y != 10'(SV_DISP + SV_FP) && s_pixel_y != 10'(SV_DISP + SV_FP + 1))
                    bad_vs++;
            end
            if (s_p_tick && s_video_on) vid_ticks++;
            @(negedge clk);
            period++;
        end while (!s_frame_start && period < 5000);
    endtask

    task automatic check_frame(input int period, input int vs_low, input int vid_ticks,
                               input int bad_vs);
        check_output("s_frame_period_clk", period, SHT * SVT * 4);
        check_output("s_vsync_low_clk", vs_low, SV_SYNC * SHT * 4);
        check_output("s_vsync_bad_line", bad_vs, 0);
        check_output("s_video_ticks", vid_ticks, SH_DISP * SV_DISP);
    endtask

    task automatic apply_stimulus();
        int period, vs_low, vid_ticks, bad_vs, wait_n, n, run_len;
        @(negedge clk);
        #2 rst_n_s = 1'b1;
        measure_frame(period, vs_low, vid_ticks, bad_vs, wait_n);
        check_output("s_first_fs_wait", wait_n, 3);
        check_frame(period, vs_low, vid_ticks, bad_vs);
        n = 0;
        while (!(s_p_tick && s_pixel_x == 10'(SHT - 1) && s_pixel_y == 10'(SVT - 1)) && n < 2500) begin
            @(negedge clk);
            n++;
        end
        check_output("s_corner_seen", (n < 2500) ? 1 : 0, 1);
        @(posedge clk);
        #1;
        check_output("s_corner_x", int'(s_pixel_x), 0);
        check_output("s_corner_y", int'(s_pixel_y), 0);
        repeat (3) @(posedge clk);
        #1;
        check_output("s_corner_ptick", int'(s_p_tick), 1);
        check_output("s_corner_frame_start", int'(s_frame_start), 1);
        n = 0;
        while (!(s_pixel_x == 10'd22 && s_pixel_y == 10'd5 && !s_hsync) && n < 2500) begin
            @(negedge clk);
            n++;
        end
        check_output("s_midline_seen", (n < 2500) ? 1 : 0, 1);
        #2 rst_n_s = 1'b0;
        #1;
        check_output("s_rst_pixel_x", int'(s_pixel_x), 0);
        check_output("s_rst_pixel_y", int'(s_pixel_y), 0);
        check_output("s_rst_hsync", int'(s_hsync), 1);
        check_output("s_rst_vsync", int'(s_vsync), 1);
        check_output("s_rst_ptick", int'(s_p_tick), 0);
        check_output("s_rst_frame_start", int'(s_frame_start), 0);
        check_output("s_rst_video_on", int'(s_video_on), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n_s = 1'b1;
        measure_frame(period, vs_low, vid_ticks, bad_vs, wait_n);
        check_output("s_fs_after_reset_wait", wait_n, 3);
        check_frame(period, vs_low, vid_ticks, bad_vs);
        for (int i = 0; i < 5; i++) begin
            run_len = $urandom_range(2500, 20);
            repeat (run_len) @(negedge clk);
            #($urandom_range(3, 1)) rst_n_s = 1'b0;
            #1;
            check_output("s_rand_rst_x", int'(s_pixel_x), 0);
            check_output("s_rand_rst_hsync", int'(s_hsync), 1);
            check_output("s_rand_rst_ptick", int'(s_p_tick), 0);
            repeat ($urandom_range(3, 1)) @(posedge clk);
            @(negedge clk);
            #($urandom_range(4, 1)) rst_n_s = 1'b1;
        end
        repeat (2500) @(negedge clk);
    endtask

    initial begin
        rst_n_d = 1'b0;
        rst_n_s = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        check_output("d_reset_pixel_x", int'(d_pixel_x), 0);
        check_output("d_reset_hsync", int'(d_hsync), 1);
        check_output("d_reset_vsync", int'(d_vsync), 1);
        check_output("d_reset_ptick", int'(d_p_tick), 0);
        check_output("d_reset_frame_start", int'(d_frame_start), 0);
        check_output("d_reset_video_on", int'(d_video_on), 1);
        fork
            run_default();
            apply_stimulus();
        join
        repeat (2) @(negedge clk);
        #1;
        check_output("sb_leftover", sb_q.size(), 0);
        $display("[TB] vga_sync bench complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
